// File: rtl/dct_nios_mem_copy_master.sv
// Avalon-MM word-copy master: reads one word, writes it, repeats until the length is exhausted.
// Optional running checksum of copied words when DCT_MEMCPY_CHECKSUM_EN is defined.
module dct_nios_mem_copy_master #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
`ifdef DCT_MEMCPY_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [LEN_W-1:0]  remaining_reg;

  // avm_writedata doubles as the one-word data buffer between read and write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      remaining_reg  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'h0;
      avm_writedata  <= 32'h0;
`ifdef DCT_MEMCPY_CHECKSUM_EN
      checksum       <= 32'h0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
`ifdef DCT_MEMCPY_CHECKSUM_EN
            checksum <= 32'h0;
`endif
            if (length == '0) begin
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              src_reg        <= src_addr;
              dst_reg        <= dst_addr;
              remaining_reg  <= length;
              busy           <= 1'b1;
              avm_read       <= 1'b1;
              avm_chipselect <= 1'b1;
              avm_byteenable <= 4'hF;
              avm_address    <= src_addr;
              state_reg      <= RD_REQ;
            end
          end
        end

        RD_REQ: begin
          if (!avm_waitrequest) begin
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_byteenable <= 4'h0;
            state_reg      <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (avm_readdatavalid) begin
            avm_writedata  <= avm_readdata;
            avm_write      <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_byteenable <= 4'hF;
            avm_address    <= dst_reg;
            state_reg      <= WR_REQ;
          end
        end

        WR_REQ: begin
          if (!avm_waitrequest) begin
            avm_write     <= 1'b0;
            src_reg       <= src_reg + ADDR_W'(1);
            dst_reg       <= dst_reg + ADDR_W'(1);
            remaining_reg <= remaining_reg - LEN_W'(1);
`ifdef DCT_MEMCPY_CHECKSUM_EN
            checksum      <= checksum + avm_writedata;
`endif
            if (remaining_reg == LEN_W'(1)) begin
              avm_chipselect <= 1'b0;
              avm_byteenable <= 4'h0;
              busy           <= 1'b0;
              done           <= 1'b1;
              state_reg      <= DONE;
            end else begin
              // Chip select and byte enables stay asserted straight into the next read.
              avm_read    <= 1'b1;
              avm_address <= src_reg + ADDR_W'(1);
              state_reg   <= RD_REQ;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dct_nios_mem_copy_master.md
DCT_NIOS_MEM_COPY_MASTER -- requirements
Module: dct_nios_mem_copy_master

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width of the master port (matches 64K-word on-chip RAM).
REQ-002 Parameter LEN_W, default 16, width of the transfer-length field in words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_W  first source word address; captured on accepted start.
REQ-007 dst_addr  input  ADDR_W  first destination word address; captured on accepted start.
REQ-008 length  input  LEN_W  number of 32-bit words to copy; captured on accepted start.
REQ-009 busy  output  1  high from the cycle after an accepted start until the done pulse.
REQ-010 done  output  1  one-cycle pulse when the copy completes.
REQ-011 avm_address  output  ADDR_W  Avalon-MM word address.
REQ-012 avm_chipselect  output  1  asserted with every read or write.
REQ-013 avm_read  output  1  read request.
REQ-014 avm_write  output  1  write request.
REQ-015 avm_byteenable  output  4  always 4'hF during a write or read.
REQ-016 avm_writedata  output  32  write data.
REQ-017 avm_readdata  input  32  read data.
REQ-018 avm_readdatavalid  input  1  readdata qualifier from the fabric.
REQ-019 avm_waitrequest  input  1  slave stall; request signals held stable while high.
REQ-020 checksum  output  32  running sum of copied words (only with DCT_MEMCPY_CHECKSUM_EN).

Function
REQ-021 FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE; one word in flight at a time.
REQ-022 IDLE: start=1 with length!=0 -> latch src/dst/length into counters, go RD_REQ; start=1 with length=0 -> go DONE, no bus activity.
REQ-023 RD_REQ: drive avm_read=1, avm_chipselect=1, avm_address=src counter; leave when avm_waitrequest=0 -> RD_WAIT.
REQ-024 RD_WAIT: all requests low; on avm_readdatavalid=1 register avm_readdata into data buffer, go WR_REQ; readdatavalid in any other state is ignored.
REQ-025 WR_REQ: drive avm_write=1, avm_chipselect=1, avm_address=dst counter, avm_writedata=buffer; when avm_waitrequest=0, increment src and dst, decrement remaining; remaining reaching 0 -> DONE, else -> RD_REQ.
REQ-026 Address counters increment modulo 2^ADDR_W (16'hFFFF wraps to 16'h0000).
REQ-027 avm_read and avm_write never asserted in the same cycle.
REQ-028 Request outputs, address and writedata held constant while avm_waitrequest=1.
REQ-029 DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
REQ-030 start while busy is ignored; latched parameters unaffected.
REQ-031 Minimum per-word cost with zero waitrequest and 1-cycle read latency: 3 cycles (RD_REQ, RD_WAIT, WR_REQ).
REQ-032 Overlapping src/dst ranges copied strictly ascending, word by word; no overlap correction.

Reset
REQ-033 reset_n=0 forces IDLE immediately, including mid-transfer; outstanding read data discarded.
REQ-034 Reset values: busy=0, done=0, avm_read=0, avm_write=0, avm_chipselect=0, avm_address=0, avm_writedata=0, avm_byteenable=4'h0, checksum=0.

Configuration
REQ-035 Macro DCT_MEMCPY_CHECKSUM_EN defined: checksum cleared on accepted start, adds each written word modulo 2^32 on write acceptance, holds value after done until next start.
REQ-036 Macro undefined: checksum port absent, no adder logic; all other behaviour identical.

Verification
REQ-037 src=16'h0100, dst=16'h0200, length=4, zero-wait memory -> mem[0x200..0x203]=mem[0x100..0x103], done pulse 12 cycles after busy rises.
REQ-038 length=0 start -> done pulse, busy low throughout, no avm_read/avm_write.
REQ-039 waitrequest held high 5 cycles on 2nd read and 3rd write -> outputs stable during stalls, data copied correctly.
REQ-040 src=16'hFFFE, dst=16'h0010, length=4 -> reads at FFFE, FFFF, 0000, 0001; writes at 0x0010-0x0013.
REQ-041 reset_n pulsed low in WR_REQ of word 2 of 8 -> all outputs at reset values same cycle; later start runs normally.
REQ-042 With DCT_MEMCPY_CHECKSUM_EN, words 1,2,3,0xFFFFFFFF copied -> checksum=32'h00000005 at done.
